// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, WAIT)
//   ifq_entry_t   : one queue entry {instruction, pc+4}
//   NOP           : value shown on the head outputs while the queue is empty
//   DEFAULT_DEPTH : default number of queue entries
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } ifq_entry_t;

  localparam logic [31:0] NOP           = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH = 4;

endpackage

// File: rtl/ifq_storage.sv
// Circular buffer of DEPTH {instruction, pc+4} entries.
// Ports:
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   push, push_data    : append an entry at the tail
//   pop                : drop the head entry
//   flush              : empty the buffer and rewind both pointers (wins)
//   head_data          : entry at the head (show-ahead)
//   count, empty, full : occupancy 0..DEPTH and its derived flags
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  ifq_entry_t                 push_data,
  input  logic                       pop,
  input  logic                       flush,
  output ifq_entry_t                 head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  ifq_entry_t    mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; DEPTH is a power of two so the pointers wrap naturally.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[head_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      if (do_push) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[tail_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: fetches sequential words from the instruction
// memory into a DEPTH-entry queue and presents the head to dispatch.
// Ports:
//   clock, reset                  : rising-edge clock, async active-high reset
//   Dispatch_ren                  : pop the head entry
//   Dispatch_jmp/Dispatch_jmp_addr: flush the queue and redirect fetch
//   ifetch_intruction/ifetch_pc_4 : head entry (zero when empty)
//   ifetch_empty                  : no valid head entry
//   Ifetch_req/Ifetch_addr        : instruction memory request
//   Icache_gnt                    : request accepted
//   Icache_rvalid/Icache_rdata    : read response
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Dispatch_ren,
  input  logic        Dispatch_jmp,
  input  logic [31:0] Dispatch_jmp_addr,
  output logic [31:0] ifetch_intruction,
  output logic [31:0] ifetch_pc_4,
  output logic        ifetch_empty,
  output logic        Ifetch_req,
  output logic [31:0] Ifetch_addr,
  input  logic        Icache_gnt,
  input  logic        Icache_rvalid,
  input  logic [31:0] Icache_rdata
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   req_addr;
  logic [31:0]   req_addr_next;
  logic          discard;
  logic          discard_next;

  logic          push;
  logic          pop;
  logic          q_empty;
  logic          q_full_unused;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          slot_free;
  ifq_entry_t    head;
  ifq_entry_t    push_entry;
  logic          jmp_addr_unused;

  // Jump targets are forced to word alignment, so the low bits are dropped.
  assign jmp_addr_unused = ^Dispatch_jmp_addr[1:0];

  // A jump flushes the queue, so it suppresses both pop and push.
  assign pop  = Dispatch_ren && !q_empty && !Dispatch_jmp;
  assign push = (state == WAIT) && Icache_rvalid && !discard && !Dispatch_jmp;

  assign push_entry.instr = Icache_rdata;
  assign push_entry.pc_4  = req_addr + 32'd4;

  // Occupancy after this edge. A new request is only launched when this
  // leaves room, which reserves the slot its response will land in.
  assign count_after = count + CW'(push) - CW'(pop);
  assign slot_free   = (count_after < CW'(DEPTH));

  ifq_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (Dispatch_jmp),
    .head_data (head),
    .count     (count),
    .empty     (q_empty),
    .full      (q_full_unused)
  );

  assign ifetch_empty      = q_empty;
  assign ifetch_intruction = q_empty ? NOP : head.instr;
  assign ifetch_pc_4       = q_empty ? NOP : head.pc_4;
  assign Ifetch_req        = (state == REQ);
  assign Ifetch_addr       = fetch_pc;

  // Fetch FSM state and address registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
      discard  <= discard_next;
    end
  end

  // Next-state logic. A jump overrides the normal flow: if a request is
  // already accepted and its data has not come back, we must still wait
  // for it (and throw it away) before issuing the redirected fetch.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    discard_next  = discard;

    case (state)
      IDLE: begin
        if (slot_free) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (Icache_gnt) begin
          state_next    = WAIT;
          req_addr_next = fetch_pc;
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      WAIT: begin
        if (Icache_rvalid) begin
          discard_next = 1'b0;
          state_next   = slot_free ? REQ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (Dispatch_jmp) begin
      fetch_pc_next = {Dispatch_jmp_addr[31:2], 2'b00};
      if (((state == REQ) && Icache_gnt) || ((state == WAIT) && !Icache_rvalid)) begin
        state_next   = WAIT;
        discard_next = 1'b1;
      end else begin
        state_next   = REQ;
        discard_next = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: an instruction-memory responder with
// programmable grant/response delays drives the DUT, and a queue-based
// reference model predicts every output each cycle.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        Dispatch_ren;
  logic        Dispatch_jmp;
  logic [31:0] Dispatch_jmp_addr;
  logic [31:0] ifetch_intruction;
  logic [31:0] ifetch_pc_4;
  logic        ifetch_empty;
  logic        Ifetch_req;
  logic [31:0] Ifetch_addr;
  logic        Icache_gnt;
  logic        Icache_rvalid;
  logic [31:0] Icache_rdata;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .Dispatch_ren      (Dispatch_ren),
    .Dispatch_jmp      (Dispatch_jmp),
    .Dispatch_jmp_addr (Dispatch_jmp_addr),
    .ifetch_intruction (ifetch_intruction),
    .ifetch_pc_4       (ifetch_pc_4),
    .ifetch_empty      (ifetch_empty),
    .Ifetch_req        (Ifetch_req),
    .Ifetch_addr       (Ifetch_addr),
    .Icache_gnt        (Icache_gnt),
    .Icache_rvalid     (Icache_rvalid),
    .Icache_rdata      (Icache_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } tb_entry_t;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // Reference model: queue contents plus what the fetcher is doing.
  tb_entry_t   m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_out_addr;
  bit          m_req;
  bit          m_out;
  bit          m_discard;

  // Memory responder state.
  bit          resp_busy;
  int          resp_cnt;
  logic [31:0] resp_addr;
  int          gnt_cnt;
  int          g_min, g_max, rv_min, rv_max;
  logic [31:0] gnt_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    e_instr = 32'h0;
    e_pc4   = 32'h0;
    if (m_q.size() != 0) begin
      e_instr = m_q[0].instr;
      e_pc4   = m_q[0].pc_4;
    end
    chk({tag, ".empty"}, {31'b0, ifetch_empty}, {31'b0, (m_q.size() == 0)});
    chk({tag, ".instr"}, ifetch_intruction, e_instr);
    chk({tag, ".pc_4"},  ifetch_pc_4, e_pc4);
    chk({tag, ".req"},   {31'b0, Ifetch_req}, {31'b0, m_req});
    chk({tag, ".addr"},  Ifetch_addr, m_pc);
  endtask

  task automatic modelReset();
    m_q.delete();
    m_pc       = RESET_PC;
    m_out_addr = RESET_PC;
    m_req      = 1'b0;
    m_out      = 1'b0;
    m_discard  = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge values.
  task automatic modelEdge(input bit ren, input bit jmp, input logic [31:0] jaddr,
                           input bit g, input bit rv, input logic [31:0] rdata);
    bit idle;
    idle = !m_req && !m_out;
    if (jmp) begin
      m_q.delete();
      if ((m_req && g) || (m_out && !rv)) begin
        m_out     = 1'b1;
        m_discard = 1'b1;
        m_req     = 1'b0;
      end else begin
        m_out     = 1'b0;
        m_discard = 1'b0;
        m_req     = 1'b1;
      end
      m_pc = {jaddr[31:2], 2'b00};
    end else begin
      if (ren && m_q.size() > 0) void'(m_q.pop_front());
      if (m_req && g) begin
        m_out      = 1'b1;
        m_req      = 1'b0;
        m_out_addr = m_pc;
        m_pc       = m_pc + 32'd4;
      end else if (m_out && rv) begin
        if (!m_discard) m_q.push_back('{instr: rdata, pc_4: m_out_addr + 32'd4});
        m_out     = 1'b0;
        m_discard = 1'b0;
        m_req     = (m_q.size() < DEPTH);
      end else if (idle && m_q.size() < DEPTH) begin
        m_req = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge) and advance to the
  // next falling edge.
  task automatic applyStimulus(input bit ren, input bit jmp, input logic [31:0] jaddr);
    bit          g;
    bit          rv;
    bit          req_before;
    logic [31:0] rd;
    g  = m_req && (gnt_cnt == 0);
    rv = resp_busy && (resp_cnt == 0);
    rd = rv ? mem_word(resp_addr) : $urandom();
    Dispatch_ren      = ren;
    Dispatch_jmp      = jmp;
    Dispatch_jmp_addr = jaddr;
    Icache_gnt        = g;
    Icache_rvalid     = rv;
    Icache_rdata      = rd;
    if (g) gnt_log.push_back(Ifetch_addr);
    if (rv) resp_busy = 1'b0;
    else if (resp_busy) resp_cnt--;
    if (g) begin
      resp_busy = 1'b1;
      resp_addr = m_pc;
      resp_cnt  = $urandom_range(rv_max - 1, rv_min - 1);
    end
    if (m_req && !g && gnt_cnt > 0) gnt_cnt--;
    req_before = m_req;
    modelEdge(ren, jmp, jaddr, g, rv, rd);
    if (m_req && (!req_before || jmp)) gnt_cnt = $urandom_range(g_max, g_min);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset(input string tag);
    reset         = 1'b1;
    Dispatch_ren  = 1'b0;
    Dispatch_jmp  = 1'b0;
    Icache_gnt    = 1'b0;
    Icache_rvalid = 1'b0;
    resp_busy     = 1'b0;
    gnt_cnt       = 0;
    modelReset();
    @(negedge clock);
    checkOutput(tag);
    reset = 1'b0;
  endtask

  initial begin
    bit          found;
    logic [31:0] exp_next;
    int          pops;

    reset             = 1'b1;
    Dispatch_ren      = 1'b0;
    Dispatch_jmp      = 1'b0;
    Dispatch_jmp_addr = 32'h0;
    Icache_gnt        = 1'b0;
    Icache_rvalid     = 1'b0;
    Icache_rdata      = 32'h0;
    resp_busy         = 1'b0;
    resp_cnt          = 0;
    resp_addr         = 32'h0;
    g_min = 0; g_max = 0; rv_min = 1; rv_max = 1;
    @(negedge clock);

    // Fill: immediate grant, data one cycle later, no dispatch.
    doReset("reset");
    gnt_log.delete();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("fill");
    end
    chk("fill.ngnt", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill.gaddr", (gnt_log.size() > i) ? gnt_log[i] : 32'hDEAD_BEEF, RESET_PC + 32'(4 * i));
    end
    chk("fill.head_pc4", ifetch_pc_4, RESET_PC + 32'd4);
    chk("fill.head_ins", ifetch_intruction, mem_word(RESET_PC));

    // One pop from a full queue triggers exactly one refill request.
    gnt_log.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("pop1");
    chk("pop1.head_pc4", ifetch_pc_4, RESET_PC + 32'd8);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("pop1");
    end
    chk("pop1.ngnt", gnt_log.size(), 1);
    chk("pop1.gaddr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, RESET_PC + 32'd16);

    // Jump while two entries are queued and a response is still pending.
    doReset("reset2");
    rv_min = 3; rv_max = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_q.size() == 2 && m_out && resp_busy && resp_cnt > 0) found = 1'b1;
      else begin
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("jwait.pre");
      end
    end
    chk("jwait.reached", {31'b0, found}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("jwait");
    chk("jwait.empty", {31'b0, ifetch_empty}, 32'd1);
    chk("jwait.addr", Ifetch_addr, 32'h100);
    gnt_log.delete();
    for (int i = 0; i < 20 && m_q.size() == 0; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("jwait.post");
    end
    chk("jwait.gaddr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'h100);
    chk("jwait.head_pc4", ifetch_pc_4, 32'h104);
    chk("jwait.head_ins", ifetch_intruction, mem_word(32'h100));

    // Jump to an unaligned target in the same cycle as grant and a pop.
    doReset("reset3");
    rv_min = 2; rv_max = 2;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("jgnt.pre");
    applyStimulus(1'b1, 1'b1, 32'h203);
    checkOutput("jgnt");
    chk("jgnt.empty", {31'b0, ifetch_empty}, 32'd1);
    chk("jgnt.req", {31'b0, Ifetch_req}, 32'd0);
    gnt_log.delete();
    for (int i = 0; i < 20 && m_q.size() == 0; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("jgnt.post");
    end
    chk("jgnt.gaddr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'h200);
    chk("jgnt.head_pc4", ifetch_pc_4, 32'h204);

    // Streaming with dispatch always reading and random memory latency.
    doReset("reset4");
    g_min = 0; g_max = 4; rv_min = 1; rv_max = 5;
    exp_next = RESET_PC + 32'd4;
    pops = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_q.size() > 0) begin
        chk("stream.order_pc4", ifetch_pc_4, exp_next);
        chk("stream.order_ins", ifetch_intruction, mem_word(exp_next - 32'd4));
        exp_next = exp_next + 32'd4;
        pops++;
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stream");
    end
    chk("stream.enough", {31'b0, (pops >= 20)}, 32'd1);

    // Random dispatch, jumps and latency against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0), $urandom());
      checkOutput("random");
    end

    // Reset while a response is outstanding; stale data arrives afterwards.
    doReset("reset5");
    g_min = 0; g_max = 0; rv_min = 4; rv_max = 4;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && resp_busy && resp_cnt > 0) found = 1'b1;
      else begin
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rwait.pre");
      end
    end
    chk("rwait.reached", {31'b0, found}, 32'd1);
    #2;
    reset         = 1'b1;
    Icache_gnt    = 1'b0;
    Icache_rvalid = 1'b0;
    Dispatch_ren  = 1'b0;
    #1;
    chk("rwait.async_req", {31'b0, Ifetch_req}, 32'd0);
    chk("rwait.async_empty", {31'b0, ifetch_empty}, 32'd1);
    chk("rwait.async_addr", Ifetch_addr, RESET_PC);
    modelReset();
    gnt_cnt = 0;
    @(negedge clock);
    checkOutput("rwait.reset");
    resp_busy = 1'b1;
    resp_cnt  = 0;
    reset     = 1'b0;
    gnt_log.delete();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rwait.stale");
    chk("rwait.stale_empty", {31'b0, ifetch_empty}, 32'd1);
    for (int i = 0; i < 20 && m_q.size() == 0; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("rwait.post");
    end
    chk("rwait.gaddr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, RESET_PC);
    chk("rwait.head_pc4", ifetch_pc_4, RESET_PC + 32'd4);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
